// File: rtl/otopilot_pkg.sv
// Shared types and constants for the autopilot mission sequencer.
package otopilot_pkg;

  localparam int unsigned HEDEF_W       = 8;
  localparam int unsigned MAX_HEDEF_DEF = 100;
  localparam int unsigned MAX_TEKRAR    = 2;

  typedef enum logic [2:0] {
    BOSTA,
    YUKLE,
    GONDER,
    BEKLE,
    SONRAKI,
    BITTI,
    HATA
  } state_e;

endpackage

// File: rtl/otopilot_komut_sirali_wp_tablo.sv
// Waypoint altitude table: synchronous write, combinational read, cleared by reset.
module otopilot_komut_sirali_wp_tablo
  import otopilot_pkg::*;
#(
  parameter int unsigned N_WP = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_wr_en,
  input  logic [$clog2(N_WP)-1:0] i_wr_addr,
  input  logic [HEDEF_W-1:0]      i_wr_data,
  input  logic [$clog2(N_WP)-1:0] i_rd_addr,
  output logic [HEDEF_W-1:0]      o_rd_data_c
);

  logic [HEDEF_W-1:0] r_mem [N_WP];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N_WP); i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data_c = r_mem[i_rd_addr];

endmodule

// File: rtl/otopilot_komut_sirali.sv
// Mission sequencer: issues waypoint altitudes to the autopilot and tracks arrival/error/timeout.
// Optional OTOPILOT_TEKRAR_EN: a timeout resends the same waypoint up to MAX_TEKRAR times.
module otopilot_komut_sirali
  import otopilot_pkg::*;
#(
  parameter int unsigned N_WP        = 4,
  parameter int unsigned MAX_HEDEF   = MAX_HEDEF_DEF,
  parameter int unsigned HOLD_CYC    = 8,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wp_wr_en_i,
  input  logic [$clog2(N_WP)-1:0] wp_addr_i,
  input  logic [HEDEF_W-1:0]      wp_data_i,
  input  logic [$clog2(N_WP):0]   wp_sayi_i,
  input  logic                    start_i,
  input  logic                    yesil_led_i,
  input  logic                    kirmizi_led_i,
  output logic [HEDEF_W-1:0]      hedef_yukseklik_o,
  output logic                    yukseklik_bilgisi_o,
  output logic [$clog2(N_WP)-1:0] wp_idx_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    hata_o
);

  localparam int unsigned AW = $clog2(N_WP);
  localparam int unsigned SW = AW + 1;
  localparam int unsigned HW = $clog2(HOLD_CYC + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  state_e             r_state, w_state_nxt;
  logic [AW-1:0]      r_wp_idx;
  logic [SW-1:0]      r_sayi;
  logic [HEDEF_W-1:0] r_hedef, w_rd_data;
  logic               r_strobe, r_busy, r_done, r_hata;
  logic [HW-1:0]      r_hold, w_hold_nxt;
  logic [TW-1:0]      r_to, w_to_nxt;
  logic               w_start, w_sayi_bad, w_last, w_tbl_we;

`ifdef OTOPILOT_TEKRAR_EN
  localparam int unsigned KW = $clog2(MAX_TEKRAR + 1);
  logic [KW-1:0] r_tekrar;
  logic          w_retry;
`endif

  assign w_start    = (r_state == BOSTA) && start_i;
  assign w_sayi_bad = (wp_sayi_i == '0) || (wp_sayi_i > SW'(N_WP));
  assign w_last     = ({1'b0, r_wp_idx} == (r_sayi - SW'(1)));
  assign w_tbl_we   = (r_state == BOSTA) && wp_wr_en_i;

  otopilot_komut_sirali_wp_tablo #(
    .N_WP(N_WP)
  ) u_wp_tablo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_wr_en    (w_tbl_we),
    .i_wr_addr  (wp_addr_i),
    .i_wr_data  (wp_data_i),
    .i_rd_addr  (r_wp_idx),
    .o_rd_data_c(w_rd_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= BOSTA;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus hold/timeout counter updates; red beats green beats timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_to_nxt    = r_to;
`ifdef OTOPILOT_TEKRAR_EN
    w_retry     = 1'b0;
`endif
    case (r_state)
      BOSTA: begin
        if (w_start) begin
          w_state_nxt = w_sayi_bad ? HATA : YUKLE;
        end
      end
      YUKLE: begin
        w_state_nxt = (w_rd_data > HEDEF_W'(MAX_HEDEF)) ? HATA : GONDER;
      end
      GONDER: begin
        w_hold_nxt  = '0;
        w_to_nxt    = '0;
        w_state_nxt = BEKLE;
      end
      BEKLE: begin
        if (r_to != TW'(TIMEOUT_CYC)) begin
          w_to_nxt = r_to + TW'(1);
        end
        if (!yesil_led_i) begin
          w_hold_nxt = '0;
        end else if (r_hold != HW'(HOLD_CYC)) begin
          w_hold_nxt = r_hold + HW'(1);
        end
        if (kirmizi_led_i) begin
          w_state_nxt = HATA;
        end else if (w_hold_nxt == HW'(HOLD_CYC)) begin
          w_state_nxt = SONRAKI;
        end else if (w_to_nxt == TW'(TIMEOUT_CYC)) begin
`ifdef OTOPILOT_TEKRAR_EN
          if (r_tekrar != KW'(MAX_TEKRAR)) begin
            w_retry     = 1'b1;
            w_state_nxt = GONDER;
          end else begin
            w_state_nxt = HATA;
          end
`else
          w_state_nxt = HATA;
`endif
        end
      end
      SONRAKI: begin
        w_state_nxt = w_last ? BITTI : YUKLE;
      end
      BITTI:   w_state_nxt = BOSTA;
      HATA:    w_state_nxt = BOSTA;
      default: w_state_nxt = BOSTA;
    endcase
  end

  // Registered outputs and mission bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wp_idx <= '0;
      r_sayi   <= '0;
      r_hedef  <= '0;
      r_strobe <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hata   <= 1'b0;
      r_hold   <= '0;
      r_to     <= '0;
    end else begin
      r_strobe <= (r_state == GONDER);
      r_hold   <= w_hold_nxt;
      r_to     <= w_to_nxt;
      case (r_state)
        BOSTA: begin
          if (start_i) begin
            r_done   <= 1'b0;
            r_hata   <= 1'b0;
            r_busy   <= 1'b1;
            r_wp_idx <= '0;
            r_sayi   <= wp_sayi_i;
          end
        end
        YUKLE: r_hedef <= w_rd_data;
        SONRAKI: begin
          if (!w_last) begin
            r_wp_idx <= r_wp_idx + AW'(1);
          end
        end
        BITTI: begin
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        HATA: begin
          r_hata <= 1'b1;
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef OTOPILOT_TEKRAR_EN
  // Retry budget is per waypoint.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tekrar <= '0;
    end else if (w_start || (r_state == SONRAKI)) begin
      r_tekrar <= '0;
    end else if (w_retry) begin
      r_tekrar <= r_tekrar + KW'(1);
    end
  end
`endif

  assign hedef_yukseklik_o   = r_hedef;
  assign yukseklik_bilgisi_o = r_strobe;
  assign wp_idx_o            = r_wp_idx;
  assign busy_o              = r_busy;
  assign done_o              = r_done;
  assign hata_o              = r_hata;

endmodule

// File: tb/tb_otopilot_komut_sirali.sv
// Directed bench for the mission sequencer; honours OTOPILOT_TEKRAR_EN for timeout expectations.
module tb_otopilot_komut_sirali;

  logic       clk;
  logic       rst_n;
  logic       wp_wr_en_i;
  logic [1:0] wp_addr_i;
  logic [7:0] wp_data_i;
  logic [2:0] wp_sayi_i;
  logic       start_i;
  logic       yesil_led_i;
  logic       kirmizi_led_i;
  logic [7:0] hedef_yukseklik_o;
  logic       yukseklik_bilgisi_o;
  logic [1:0] wp_idx_o;
  logic       busy_o;
  logic       done_o;
  logic       hata_o;

`ifdef OTOPILOT_TEKRAR_EN
  localparam int TO_STROBES = 3;
  localparam int HATA_LAT   = 195;
`else
  localparam int TO_STROBES = 1;
  localparam int HATA_LAT   = 65;
`endif

  otopilot_komut_sirali dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .wp_wr_en_i         (wp_wr_en_i),
    .wp_addr_i          (wp_addr_i),
    .wp_data_i          (wp_data_i),
    .wp_sayi_i          (wp_sayi_i),
    .start_i            (start_i),
    .yesil_led_i        (yesil_led_i),
    .kirmizi_led_i      (kirmizi_led_i),
    .hedef_yukseklik_o  (hedef_yukseklik_o),
    .yukseklik_bilgisi_o(yukseklik_bilgisi_o),
    .wp_idx_o           (wp_idx_o),
    .busy_o             (busy_o),
    .done_o             (done_o),
    .hata_o             (hata_o)
  );

  typedef struct {
    logic [3:0][7:0] tbl;
    int              sayi;
    int              n_str;
    int              done;
    int              hata;
    int              idx;
  } vec_t;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int sv_q[$];
  int sc_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe log: value and cycle of every issued waypoint.
  always @(negedge clk) begin
    if (rst_n && yukseklik_bilgisi_o) begin
      sv_q.push_back(int'(hedef_yukseklik_o));
      sc_q.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic write_tbl(input logic [3:0][7:0] t);
    for (int i = 0; i < 4; i++) begin
      wp_wr_en_i = 1'b1;
      wp_addr_i  = 2'(i);
      wp_data_i  = t[i];
      tick();
    end
    wp_wr_en_i = 1'b0;
  endtask

  task automatic do_start(input int sayi);
    wp_sayi_i = 3'(sayi);
    start_i   = 1'b1;
    tick();
    start_i   = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy_o && n < 1000) begin
      tick();
      n++;
    end
    chk({nm, "_idle"}, 32'(busy_o), 32'd0);
  endtask

  task automatic wait_strobe(input string nm);
    int n = 0;
    while (!yukseklik_bilgisi_o && n < 200) begin
      tick();
      n++;
    end
    chk({nm, "_strobe"}, 32'(yukseklik_bilgisi_o), 32'd1);
  endtask

  function automatic vec_t mk(input int a, input int b, input int c, input int d,
                              input int sayi, input int ns, input int dn,
                              input int ht, input int ix);
    vec_t v;
    v.tbl[0] = 8'(a);
    v.tbl[1] = 8'(b);
    v.tbl[2] = 8'(c);
    v.tbl[3] = 8'(d);
    v.sayi   = sayi;
    v.n_str  = ns;
    v.done   = dn;
    v.hata   = ht;
    v.idx    = ix;
    return v;
  endfunction

  initial begin
    vec_t vecs[7];
    int   b;
    int   t0;
    int   s;
    int   n;
    int   m;

    vecs[0] = mk(5,   7,   9,   20,  4, 4, 1, 0, 3);
    vecs[1] = mk(110, 7,   9,   20,  4, 0, 0, 1, 0);
    vecs[2] = mk(10,  101, 9,   20,  4, 1, 0, 1, 1);
    vecs[3] = mk(100, 0,   200, 255, 2, 2, 1, 0, 1);
    vecs[4] = mk(1,   2,   3,   4,   0, 0, 0, 1, 0);
    vecs[5] = mk(1,   2,   3,   4,   5, 0, 0, 1, 0);
    vecs[6] = mk(42,  200, 200, 200, 1, 1, 1, 0, 0);

    rst_n         = 1'b0;
    wp_wr_en_i    = 1'b0;
    wp_addr_i     = '0;
    wp_data_i     = '0;
    wp_sayi_i     = '0;
    start_i       = 1'b0;
    yesil_led_i   = 1'b0;
    kirmizi_led_i = 1'b0;
    tick();
    tick();
    chk("rst_hedef",  32'(hedef_yukseklik_o),   32'd0);
    chk("rst_strobe", 32'(yukseklik_bilgisi_o), 32'd0);
    chk("rst_idx",    32'(wp_idx_o),            32'd0);
    chk("rst_busy",   32'(busy_o),              32'd0);
    chk("rst_done",   32'(done_o),              32'd0);
    chk("rst_hata",   32'(hata_o),              32'd0);
    rst_n = 1'b1;
    tick();

    // Table-driven missions with a cooperative autopilot (green held high).
    for (int k = 0; k < 7; k++) begin
      write_tbl(vecs[k].tbl);
      b           = sv_q.size();
      yesil_led_i = 1'b1;
      do_start(vecs[k].sayi);
      t0 = cyc;
      wait_idle($sformatf("v%0d", k));
      yesil_led_i = 1'b0;
      tick();
      chk($sformatf("v%0d_nstr", k), 32'(sv_q.size() - b), 32'(vecs[k].n_str));
      m = (sv_q.size() - b < vecs[k].n_str) ? sv_q.size() - b : vecs[k].n_str;
      for (int j = 0; j < m; j++) begin
        chk($sformatf("v%0d_val%0d", k, j), 32'(sv_q[b+j]), 32'(vecs[k].tbl[j]));
      end
      if (vecs[k].n_str > 0 && sv_q.size() > b) begin
        chk($sformatf("v%0d_lat", k), 32'(sc_q[b] - t0), 32'd2);
      end
      chk($sformatf("v%0d_done", k), 32'(done_o),   32'(vecs[k].done));
      chk($sformatf("v%0d_hata", k), 32'(hata_o),   32'(vecs[k].hata));
      chk($sformatf("v%0d_idx", k),  32'(wp_idx_o), 32'(vecs[k].idx));
    end

    // Red LED on the fifth wait cycle aborts the mission.
    write_tbl({8'd0, 8'd0, 8'd0, 8'd50});
    b = sv_q.size();
    do_start(1);
    wait_strobe("red");
    repeat (4) tick();
    kirmizi_led_i = 1'b1;
    tick();
    kirmizi_led_i = 1'b0;
    tick();
    chk("red_hata", 32'(hata_o),   32'd1);
    chk("red_busy", 32'(busy_o),   32'd0);
    chk("red_done", 32'(done_o),   32'd0);
    chk("red_idx",  32'(wp_idx_o), 32'd0);
    repeat (3) tick();
    chk("red_nstr", 32'(sv_q.size() - b), 32'd1);

    // Green dropping for one cycle restarts the hold count.
    write_tbl({8'd0, 8'd0, 8'd7, 8'd5});
    b = sv_q.size();
    do_start(2);
    wait_strobe("gl");
    yesil_led_i = 1'b1;
    repeat (7) tick();
    yesil_led_i = 1'b0;
    tick();
    yesil_led_i = 1'b1;
    repeat (8) tick();
    wait_idle("gl");
    yesil_led_i = 1'b0;
    tick();
    chk("gl_nstr", 32'(sv_q.size() - b), 32'd2);
    if (sv_q.size() - b >= 2) begin
      chk("gl_gap",  32'(sc_q[b+1] - sc_q[b]), 32'd19);
      chk("gl_val0", 32'(sv_q[b]),   32'd5);
      chk("gl_val1", 32'(sv_q[b+1]), 32'd7);
    end
    chk("gl_done", 32'(done_o), 32'd1);
    chk("gl_hata", 32'(hata_o), 32'd0);

    // No arrival at all: timeout (and retries when enabled).
    write_tbl({8'd0, 8'd0, 8'd0, 8'd33});
    b = sv_q.size();
    do_start(1);
    wait_strobe("to");
    s = cyc;
    n = 0;
    while (!hata_o && n < 400) begin
      tick();
      n++;
    end
    chk("to_hata", 32'(hata_o),  32'd1);
    chk("to_lat",  32'(cyc - s), 32'(HATA_LAT));
    tick();
    chk("to_nstr", 32'(sv_q.size() - b), 32'(TO_STROBES));
    for (int j = b; j < sv_q.size(); j++) begin
      chk("to_val", 32'(sv_q[j]), 32'd33);
    end
    chk("to_done", 32'(done_o), 32'd0);

    // Reset while waiting: everything clears, table included, then restart works.
    write_tbl({8'd20, 8'd9, 8'd7, 8'd5});
    do_start(4);
    wait_strobe("mr");
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    chk("mr_hedef",  32'(hedef_yukseklik_o),   32'd0);
    chk("mr_strobe", 32'(yukseklik_bilgisi_o), 32'd0);
    chk("mr_idx",    32'(wp_idx_o),            32'd0);
    chk("mr_busy",   32'(busy_o),              32'd0);
    chk("mr_done",   32'(done_o),              32'd0);
    chk("mr_hata",   32'(hata_o),              32'd0);
    rst_n = 1'b1;
    b = sv_q.size();
    repeat (5) tick();
    chk("mr_quiet", 32'(sv_q.size() - b), 32'd0);
    yesil_led_i = 1'b1;
    do_start(1);
    wait_idle("mr");
    yesil_led_i = 1'b0;
    tick();
    chk("mr_nstr", 32'(sv_q.size() - b), 32'd1);
    if (sv_q.size() > b) begin
      chk("mr_val", 32'(sv_q[b]), 32'd0);
    end
    chk("mr_done2", 32'(done_o), 32'd1);
    chk("mr_hata2", 32'(hata_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
